// File: rtl/lcd_read_controller_if.sv
// Character-LCD bus as seen by the read controller: control lines driven,
// data bus sampled.
interface lcd_read_controller_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (
    input  LCD_DATA,
    output LCD_RW,
    output LCD_EN,
    output LCD_RS
  );

  modport slave (
    output LCD_DATA,
    input  LCD_RW,
    input  LCD_EN,
    input  LCD_RS
  );
endinterface

// File: rtl/lcd_read_controller.sv
// HD44780 read-cycle sequencer: single reads or busy-flag polling with
// programmable setup / enable-high / enable-low phases. All outputs registered.
module lcd_read_controller #(
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 16,
  parameter int EN_LOW_CYC  = 16,
  parameter int POLL_LIMIT  = 4096
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         iStart,
  input  logic                         iRS,
  input  logic                         iPoll,
  output logic [7:0]                   oDATA,
  output logic                         oDone,
  output logic                         oBusy,
  output logic                         oTimeout,
  lcd_read_controller_if.master        lcd
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EN_HI = 3'd2;
  localparam logic [2:0] ST_EN_LO = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HIGH_LAST  = 16'(EN_HIGH_CYC - 1);
  localparam logic [15:0] LOW_LAST   = 16'(EN_LOW_CYC - 1);
  localparam logic [15:0] POLL_LIM   = 16'(POLL_LIMIT);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_poll_cnt;
  logic        r_rs;
  logic        r_poll_mode;
  logic [7:0]  r_data;
  logic        r_done;
  logic        r_busy;
  logic        r_timeout;
  logic        r_lcd_en;
  logic        r_lcd_rw;
  logic        r_lcd_rs;

  logic [2:0]  w_next_state;
  logic [15:0] w_cnt_next;
  logic        w_phase_end;
  logic        w_repoll;
  logic        w_accept;

  assign w_accept = (r_state == ST_IDLE) && iStart;
  // Another poll read only while BF is still set and the read budget remains.
  assign w_repoll = r_poll_mode && r_data[7] && (r_poll_cnt < POLL_LIM);

  // Phase-end detection, next-state and phase counter selection
  always_comb begin
    w_phase_end  = 1'b0;
    w_next_state = ST_IDLE;
    case (r_state)
      ST_SETUP: w_phase_end = (r_cnt == SETUP_LAST);
      ST_EN_HI: w_phase_end = (r_cnt == HIGH_LAST);
      ST_EN_LO: w_phase_end = (r_cnt == LOW_LAST);
      default:  w_phase_end = 1'b0;
    endcase

    case (r_state)
      ST_IDLE:  w_next_state = iStart ? ST_SETUP : ST_IDLE;
      ST_SETUP: w_next_state = w_phase_end ? ST_EN_HI : ST_SETUP;
      ST_EN_HI: w_next_state = w_phase_end ? ST_EN_LO : ST_EN_HI;
      ST_EN_LO: begin
        if (w_phase_end) begin
          w_next_state = w_repoll ? ST_SETUP : ST_DONE;
        end else begin
          w_next_state = ST_EN_LO;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase

    if ((r_state == ST_IDLE) || (w_next_state != r_state)) begin
      w_cnt_next = 16'd0;
    end else begin
      w_cnt_next = r_cnt + 16'd1;
    end
  end

  // State, phase counter and per-request latches
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_poll_cnt  <= 16'd0;
      r_rs        <= 1'b0;
      r_poll_mode <= 1'b0;
      r_data      <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rs        <= iRS;
        r_poll_mode <= iPoll & ~iRS;
        r_poll_cnt  <= 16'd0;
        r_timeout   <= 1'b0;
      end
      if ((r_state == ST_EN_HI) && w_phase_end) begin
        r_data     <= lcd.LCD_DATA;
        r_poll_cnt <= r_poll_cnt + 16'd1;
      end
      if ((r_state == ST_EN_LO) && w_phase_end && !w_repoll) begin
        r_timeout <= r_poll_mode & r_data[7];
      end
    end
  end

  // Registered bus and status outputs decoded from the upcoming state
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_lcd_en <= 1'b0;
      r_lcd_rw <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_lcd_en <= (w_next_state == ST_EN_HI);
      r_lcd_rw <= (w_next_state != ST_IDLE);
      r_lcd_rs <= (w_next_state != ST_IDLE) && (w_accept ? iRS : r_rs);
      r_busy   <= (w_next_state != ST_IDLE);
      r_done   <= (w_next_state == ST_DONE);
    end
  end

  assign oDATA      = r_data;
  assign oDone      = r_done;
  assign oBusy      = r_busy;
  assign oTimeout   = r_timeout;
  assign lcd.LCD_EN = r_lcd_en;
  assign lcd.LCD_RW = r_lcd_rw;
  assign lcd.LCD_RS = r_lcd_rs;

endmodule

// File: tb/tb_lcd_read_controller.sv
// Directed bench for lcd_read_controller: stimulus queues expected completions,
// a monitor checks each oDone against them.
module tb_lcd_read_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPoll = 1'b0;
  logic [7:0] oDATA;
  logic       oDone;
  logic       oBusy;
  logic       oTimeout;
  logic [7:0] lcd_data_drv = 8'h00;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s = 0;
  int en_pulses = 0;
  int p0 = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       to;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rsp_q[$];

  lcd_read_controller_if lcd_if ();
  assign lcd_if.LCD_DATA = lcd_data_drv;

  lcd_read_controller #(
    .SETUP_CYC   (4),
    .EN_HIGH_CYC (16),
    .EN_LOW_CYC  (16),
    .POLL_LIMIT  (4)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .iStart   (iStart),
    .iRS      (iRS),
    .iPoll    (iPoll),
    .oDATA    (oDATA),
    .oDone    (oDone),
    .oBusy    (oBusy),
    .oTimeout (oTimeout),
    .lcd      (lcd_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LCD model: each rising enable presents the next queued byte
  always @(posedge lcd_if.LCD_EN) begin
    en_pulses++;
    if (rsp_q.size() > 0) lcd_data_drv = rsp_q.pop_front();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - s);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && oDone) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_data", 32'(oDATA), 32'(e.d));
        chk("done_timeout", 32'(oTimeout), 32'(e.to));
      end
    end
  end

  task automatic wait_cyc(input int k);
    while (cyc < s + k) @(negedge clk);
  endtask

  task automatic issue(input logic rs, input logic poll, input int lat,
                       input logic [7:0] d, input logic to, input bit push);
    exp_t e;
    @(negedge clk);
    iRS = rs;
    iPoll = poll;
    iStart = 1'b1;
    s = cyc;
    p0 = en_pulses;
    if (push) begin
      e.cyc = s + lat;
      e.d = d;
      e.to = to;
      exp_q.push_back(e);
    end
    @(negedge clk);
    iStart = 1'b0;
  endtask

  initial begin
    exp_t e2;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({lcd_if.LCD_EN, lcd_if.LCD_RW, lcd_if.LCD_RS, oBusy, oDone, oTimeout}), 32'd0);
    chk("reset_data", 32'(oDATA), 32'd0);
    rst_n = 1'b1;

    // single data read
    rsp_q.push_back(8'h41);
    issue(1'b1, 1'b0, 37, 8'h41, 1'b0, 1'b1);
    chk("t1_rs_c1", 32'(lcd_if.LCD_RS), 32'd1);
    chk("t1_rw_c1", 32'(lcd_if.LCD_RW), 32'd1);
    chk("t1_busy_c1", 32'(oBusy), 32'd1);
    chk("t1_en_c1", 32'(lcd_if.LCD_EN), 32'd0);
    wait_cyc(4);  chk("t1_en_c4", 32'(lcd_if.LCD_EN), 32'd0);
    wait_cyc(5);  chk("t1_en_c5", 32'(lcd_if.LCD_EN), 32'd1);
    wait_cyc(20); chk("t1_en_c20", 32'(lcd_if.LCD_EN), 32'd1);
    chk("t1_data_c20", 32'(oDATA), 32'd0);
    wait_cyc(21); chk("t1_en_c21", 32'(lcd_if.LCD_EN), 32'd0);
    chk("t1_data_c21", 32'(oDATA), 32'h41);
    wait_cyc(38);
    chk("t1_rw_c38", 32'(lcd_if.LCD_RW), 32'd0);
    chk("t1_busy_c38", 32'(oBusy), 32'd0);
    chk("t1_pulses", 32'(en_pulses - p0), 32'd1);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // busy poll clears on third read
    rsp_q.push_back(8'h80); rsp_q.push_back(8'h80); rsp_q.push_back(8'h05);
    issue(1'b0, 1'b1, 109, 8'h05, 1'b0, 1'b1);
    chk("t2_rs_c1", 32'(lcd_if.LCD_RS), 32'd0);
    wait_cyc(41); chk("t2_en_c41", 32'(lcd_if.LCD_EN), 32'd1);
    wait_cyc(110);
    chk("t2_pulses", 32'(en_pulses - p0), 32'd3);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // poll timeout after POLL_LIMIT reads
    repeat (4) rsp_q.push_back(8'hFF);
    issue(1'b0, 1'b1, 145, 8'hFF, 1'b1, 1'b1);
    wait_cyc(147);
    chk("t3_pulses", 32'(en_pulses - p0), 32'd4);
    chk("t3_to_hold", 32'(oTimeout), 32'd1);
    chk("t3_busy", 32'(oBusy), 32'd0);
    chk("t3_pending", 32'(exp_q.size()), 32'd0);
    rsp_q.push_back(8'h12);
    issue(1'b1, 1'b0, 37, 8'h12, 1'b0, 1'b1);
    chk("t3_to_clr", 32'(oTimeout), 32'd0);
    wait_cyc(38);
    chk("t3b_pending", 32'(exp_q.size()), 32'd0);

    // iPoll ignored for data reads
    rsp_q.push_back(8'h80);
    issue(1'b1, 1'b1, 37, 8'h80, 1'b0, 1'b1);
    wait_cyc(38);
    chk("t4_pulses", 32'(en_pulses - p0), 32'd1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // start while busy, then start the cycle after done
    rsp_q.push_back(8'h33); rsp_q.push_back(8'h44);
    issue(1'b1, 1'b0, 37, 8'h33, 1'b0, 1'b1);
    wait_cyc(10); iStart = 1'b1;
    wait_cyc(11); iStart = 1'b0;
    wait_cyc(37); iStart = 1'b1;
    wait_cyc(38);
    chk("t5_pulses", 32'(en_pulses - p0), 32'd1);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    s = cyc;
    p0 = en_pulses;
    e2.cyc = s + 37; e2.d = 8'h44; e2.to = 1'b0;
    exp_q.push_back(e2);
    wait_cyc(1); iStart = 1'b0;
    chk("t5_busy_new", 32'(oBusy), 32'd1);
    wait_cyc(38);
    chk("t5b_pulses", 32'(en_pulses - p0), 32'd1);
    chk("t5b_pending", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during EN high
    rsp_q.push_back(8'h55);
    issue(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    wait_cyc(10);
    chk("t6_en_pre", 32'(lcd_if.LCD_EN), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en_rst", 32'(lcd_if.LCD_EN), 32'd0);
    chk("t6_rw_rst", 32'(lcd_if.LCD_RW), 32'd0);
    chk("t6_busy_rst", 32'(oBusy), 32'd0);
    chk("t6_data_rst", 32'(oDATA), 32'd0);
    wait_cyc(13);
    rst_n = 1'b1;
    rsp_q.push_back(8'h66);
    issue(1'b1, 1'b0, 37, 8'h66, 1'b0, 1'b1);
    wait_cyc(38);
    chk("t6_data_after", 32'(oDATA), 32'h66);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
